pipeline_hazard_ctrl: RTL and testbench

//   Central sequencer for the 5-stage pipeline front end. Generates hazard_detected and halt_detected for the

---
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between decode/EX/MEM pipeline registers and the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_halt;
  logic             ex_is_load;
  logic             ex_reg_write;
  logic [REG_W-1:0] ex_rd;
  logic             mem_reg_write;
  logic [REG_W-1:0] mem_rd;
  logic             ex_branch_taken;
  logic             hazard_detected;
  logic             halt_detected;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_halt, ex_is_load, ex_reg_write, ex_rd,
           mem_reg_write, mem_rd, ex_branch_taken,
    input  hazard_detected, halt_detected, flush_if_id, bubble_id_ex, halted,
           stall_count, flush_count, cycle_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_halt, ex_is_load, ex_reg_write, ex_rd,
           mem_reg_write, mem_rd, ex_branch_taken,
    output hazard_detected, halt_detected, flush_if_id, bubble_id_ex, halted,
           stall_count, flush_count, cycle_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline front-end sequencer: RAW/load-use stall, branch flush, HALT drain, performance counters.
//   state    | meaning
//   S_RUN    | normal issue; stalls and flushes resolved per cycle
//   S_DRAIN  | HALT accepted; in-flight instructions retiring, drain_cnt counts down
//   S_HALTED | pipeline empty; sticky until rst
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int FORWARDING   = 1
) (
  input logic                   clock,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hif
);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t           state, state_nxt;
  logic [3:0]       drain_cnt, drain_nxt;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, cycle_cnt;

  logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic             raw_ex, raw_mem, hz;
  logic             hazard_c, halt_c, flush_c, bubble_c, stall_inc, flush_inc;

  assign id_rs  = hif.id_rs;
  assign id_rt  = hif.id_rt;
  assign ex_rd  = hif.ex_rd;
  assign mem_rd = hif.mem_rd;

  always_comb begin
    raw_ex  = hif.ex_reg_write && (ex_rd != '0) &&
              ((ex_rd == id_rs) || (hif.id_uses_rt && (ex_rd == id_rt)));
    raw_mem = hif.mem_reg_write && (mem_rd != '0) &&
              ((mem_rd == id_rs) || (hif.id_uses_rt && (mem_rd == id_rt)));
    // With forwarding only a load in EX cannot supply its result in time.
    if (FORWARDING != 0) hz = raw_ex && hif.ex_is_load;
    else                 hz = raw_ex || raw_mem;
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    hazard_c  = 1'b0;
    halt_c    = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      S_RUN: begin
        if (hif.ex_branch_taken) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          flush_inc = 1'b1;
        end else if (hz) begin
          hazard_c  = 1'b1;
          bubble_c  = 1'b1;
          stall_inc = 1'b1;
        end else if (hif.id_is_halt) begin
          halt_c    = 1'b1;
          flush_c   = 1'b1;
          drain_nxt = DRAIN_LOAD;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        halt_c    = 1'b1;
        flush_c   = 1'b1;
        bubble_c  = 1'b1;
        drain_nxt = drain_cnt - 4'd1;
        if (drain_cnt == 4'd1) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        halt_c   = 1'b1;
        flush_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      halted_q  <= (state_nxt == S_HALTED);
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if ((state != S_HALTED) && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign hif.hazard_detected = hazard_c;
  assign hif.halt_detected   = halt_c;
  assign hif.flush_if_id     = flush_c;
  assign hif.bubble_id_ex    = bubble_c;
  assign hif.halted          = halted_q;
  assign hif.stall_count     = stall_cnt;
  assign hif.flush_count     = flush_cnt;
  assign hif.cycle_count     = cycle_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a forwarding instance and a narrow-counter non-forwarding instance
// driven with identical stimulus and checked against a per-cycle expectation queue.
module tb_pipeline_hazard_ctrl;
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) ifa ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  ifb ();

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32), .DRAIN_CYCLES(3), .FORWARDING(1)) u_a (
    .clock(clock), .rst(rst), .hif(ifa.slave));
  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4), .DRAIN_CYCLES(3), .FORWARDING(0)) u_b (
    .clock(clock), .rst(rst), .hif(ifb.slave));

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_halt;
    logic       ex_load;
    logic       ex_wr;
    logic [4:0] ex_rd;
    logic       mem_wr;
    logic [4:0] mem_rd;
    logic       br;
  } vec_t;

  typedef struct packed {
    logic hz_a;
    logic bb_a;
    logic hz_b;
    logic bb_b;
    logic fl;
    logic hd;
    logic hl;
  } exp_t;

  typedef struct packed {
    vec_t v;
    exp_t e;
  } rec_t;

  int    checks = 0;
  int    errors = 0;
  int    run_cycles = 0;
  int    exp_stall_a = 0, exp_stall_b = 0, exp_flush = 0;
  int    n_accept;
  exp_t  sb_q[$];
  string nm_q[$];
  rec_t  tbl[13];
  string tbl_nm[13];

  function automatic vec_t mkv(input int rs, input int rt, input bit uses_rt, input bit halt,
                               input bit ld, input bit exwr, input int exrd, input bit memwr,
                               input int memrd, input bit br);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses_rt; v.is_halt = halt;
    v.ex_load = ld; v.ex_wr = exwr; v.ex_rd = 5'(exrd);
    v.mem_wr = memwr; v.mem_rd = 5'(memrd); v.br = br;
    return v;
  endfunction

  function automatic exp_t mke(input bit hz_a, input bit bb_a, input bit hz_b, input bit bb_b,
                               input bit fl, input bit hd, input bit hl);
    exp_t e;
    e.hz_a = hz_a; e.bb_a = bb_a; e.hz_b = hz_b; e.bb_b = bb_b;
    e.fl = fl; e.hd = hd; e.hl = hl;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    ifa.id_rs = v.rs;           ifb.id_rs = v.rs;
    ifa.id_rt = v.rt;           ifb.id_rt = v.rt;
    ifa.id_uses_rt = v.uses_rt; ifb.id_uses_rt = v.uses_rt;
    ifa.id_is_halt = v.is_halt; ifb.id_is_halt = v.is_halt;
    ifa.ex_is_load = v.ex_load; ifb.ex_is_load = v.ex_load;
    ifa.ex_reg_write = v.ex_wr; ifb.ex_reg_write = v.ex_wr;
    ifa.ex_rd = v.ex_rd;        ifb.ex_rd = v.ex_rd;
    ifa.mem_reg_write = v.mem_wr; ifb.mem_reg_write = v.mem_wr;
    ifa.mem_rd = v.mem_rd;      ifb.mem_rd = v.mem_rd;
    ifa.ex_branch_taken = v.br; ifb.ex_branch_taken = v.br;
  endtask

  task automatic check_out();
    exp_t  e;
    string nm;
    e  = sb_q.pop_front();
    nm = nm_q.pop_front();
    chk({nm, ".a.hazard"}, 32'(ifa.hazard_detected), 32'(e.hz_a));
    chk({nm, ".a.bubble"}, 32'(ifa.bubble_id_ex),    32'(e.bb_a));
    chk({nm, ".a.flush"},  32'(ifa.flush_if_id),     32'(e.fl));
    chk({nm, ".a.halt"},   32'(ifa.halt_detected),   32'(e.hd));
    chk({nm, ".a.halted"}, 32'(ifa.halted),          32'(e.hl));
    chk({nm, ".b.hazard"}, 32'(ifb.hazard_detected), 32'(e.hz_b));
    chk({nm, ".b.bubble"}, 32'(ifb.bubble_id_ex),    32'(e.bb_b));
    chk({nm, ".b.flush"},  32'(ifb.flush_if_id),     32'(e.fl));
    chk({nm, ".b.halt"},   32'(ifb.halt_detected),   32'(e.hd));
    chk({nm, ".b.halted"}, 32'(ifb.halted),          32'(e.hl));
  endtask

  // One clock: inputs applied just after a rising edge, outputs compared on the falling edge.
  task automatic cycle(input vec_t v, input string nm, input exp_t e);
    drive(v);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clock);
    check_out();
    @(posedge clock);
    #1;
    if (!e.hl) run_cycles++;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, ".a.hazard"}, 32'(ifa.hazard_detected), 0);
    chk({nm, ".a.halt"},   32'(ifa.halt_detected),   0);
    chk({nm, ".a.flush"},  32'(ifa.flush_if_id),     0);
    chk({nm, ".a.bubble"}, 32'(ifa.bubble_id_ex),    0);
    chk({nm, ".a.halted"}, 32'(ifa.halted),          0);
    chk({nm, ".a.stall"},  ifa.stall_count,          0);
    chk({nm, ".a.flushc"}, ifa.flush_count,          0);
    chk({nm, ".a.cycle"},  ifa.cycle_count,          0);
    chk({nm, ".b.halt"},   32'(ifb.halt_detected),   0);
    chk({nm, ".b.cycle"},  32'(ifb.cycle_count),     0);
  endtask

  initial begin
    vec_t idle, lu, hlt;
    idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mkv(5, 0, 0, 0, 1, 1, 5, 0, 0, 0);
    hlt  = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{mkv(0,0,0,0, 0,0,0, 0,0, 0), mke(0,0,0,0,0,0,0)}; tbl_nm[0]  = "idle";
    tbl[1]  = '{mkv(5,0,0,0, 1,1,5, 0,0, 0), mke(1,1,1,1,0,0,0)}; tbl_nm[1]  = "loaduse_rs";
    tbl[2]  = '{mkv(0,0,0,0, 1,1,0, 0,0, 0), mke(0,0,0,0,0,0,0)}; tbl_nm[2]  = "load_r0";
    tbl[3]  = '{mkv(0,7,1,0, 0,0,0, 1,7, 0), mke(0,0,1,1,0,0,0)}; tbl_nm[3]  = "mem_raw_rt";
    tbl[4]  = '{mkv(3,7,0,0, 0,0,0, 1,7, 0), mke(0,0,0,0,0,0,0)}; tbl_nm[4]  = "mem_rt_unused";
    tbl[5]  = '{mkv(9,0,0,0, 0,1,9, 0,0, 0), mke(0,0,1,1,0,0,0)}; tbl_nm[5]  = "ex_alu_raw";
    tbl[6]  = '{mkv(1,4,1,0, 1,1,4, 0,0, 0), mke(1,1,1,1,0,0,0)}; tbl_nm[6]  = "loaduse_rt";
    tbl[7]  = '{mkv(1,4,0,0, 1,1,4, 0,0, 0), mke(0,0,0,0,0,0,0)}; tbl_nm[7]  = "load_rt_unused";
    tbl[8]  = '{mkv(5,0,0,0, 1,1,5, 0,0, 1), mke(0,1,0,1,1,0,0)}; tbl_nm[8]  = "branch_over_stall";
    tbl[9]  = '{mkv(0,0,0,1, 0,0,0, 0,0, 1), mke(0,1,0,1,1,0,0)}; tbl_nm[9]  = "halt_wrong_path";
    tbl[10] = '{mkv(6,0,0,1, 1,1,6, 0,0, 0), mke(1,1,1,1,0,0,0)}; tbl_nm[10] = "halt_during_stall";
    tbl[11] = '{mkv(5,0,0,0, 1,0,5, 0,0, 0), mke(0,0,0,0,0,0,0)}; tbl_nm[11] = "load_nowrite";
    tbl[12] = '{mkv(0,0,0,0, 0,0,0, 1,0, 0), mke(0,0,0,0,0,0,0)}; tbl_nm[12] = "mem_r0";

    // Reset state
    drive(idle);
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single-cycle decode table, all in RUN
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl_nm[i], tbl[i].e);
      exp_stall_a += int'(tbl[i].e.hz_a);
      exp_stall_b += int'(tbl[i].e.hz_b);
      exp_flush   += int'(tbl[i].e.fl);
    end
    chk("tbl.a.stall_count", ifa.stall_count, exp_stall_a);
    chk("tbl.b.stall_count", 32'(ifb.stall_count), exp_stall_b);
    chk("tbl.a.flush_count", ifa.flush_count, exp_flush);
    chk("tbl.b.flush_count", 32'(ifb.flush_count), exp_flush);
    chk("tbl.a.cycle_count", ifa.cycle_count, run_cycles);

    // Long stall: narrow counters saturate, wide ones keep counting
    for (int i = 0; i < 14; i++) cycle(lu, "long_stall", mke(1,1,1,1,0,0,0));
    chk("sat.a.stall_count", ifa.stall_count, exp_stall_a + 14);
    chk("sat.b.stall_count", 32'(ifb.stall_count), 15);
    chk("sat.b.cycle_count", 32'(ifb.cycle_count), 15);
    chk("sat.a.cycle_count", ifa.cycle_count, run_cycles);

    // HALT acceptance and drain; branch and load-use inside DRAIN are ignored
    cycle(hlt, "halt_accept", mke(0,0,0,0,1,1,0));
    n_accept = run_cycles;
    cycle(idle, "drain1", mke(0,1,0,1,1,1,0));
    cycle(mkv(5,0,0,0, 1,1,5, 0,0, 1), "drain2_branch", mke(0,1,0,1,1,1,0));
    cycle(idle, "drain3", mke(0,1,0,1,1,1,0));
    cycle(idle, "halted1", mke(0,1,0,1,1,1,1));
    cycle(lu,   "halted2", mke(0,1,0,1,1,1,1));
    chk("halt.a.cycle_count", ifa.cycle_count, n_accept + 3);
    chk("halt.a.flush_count", ifa.flush_count, exp_flush);
    chk("halt.a.stall_count", ifa.stall_count, exp_stall_a + 14);

    // Reset out of HALTED, then an asynchronous reset in the middle of DRAIN
    rst = 1'b1;
    #1;
    chk("rst_from_halted.a.halted", 32'(ifa.halted), 0);
    #2 rst = 1'b0;
    @(posedge clock);
    #1;
    run_cycles = 1;
    cycle(hlt, "halt_accept2", mke(0,0,0,0,1,1,0));
    cycle(idle, "drain1b", mke(0,1,0,1,1,1,0));
    drive(idle);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid_drain");
    #3 rst = 1'b0;
    @(posedge clock);
    #1;
    run_cycles = 1;

    // HALT is accepted again after the mid-drain reset
    cycle(hlt, "halt_accept3", mke(0,0,0,0,1,1,0));
    n_accept = run_cycles;
    for (int i = 0; i < 3; i++) cycle(idle, "drain_c", mke(0,1,0,1,1,1,0));
    cycle(idle, "halted3", mke(0,1,0,1,1,1,1));
    chk("rehalt.a.cycle_count", ifa.cycle_count, n_accept + 3);
    chk("rehalt.a.stall_count", ifa.stall_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
